// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central hazard controller for the 5-stage RV32 pipeline. It decides, each
// cycle, which pipeline registers hold, which get a bubble or NOP, and when
// a multi-cycle MUL/DIV result may leave EX. All hazard outputs are
// combinational from the current inputs and state. The only state is the
// MUL/DIV occupancy sequencer and a stall-cycle performance counter.

module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 33,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_en,
  input  logic        id_rs2_en,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rd_en,
  input  logic        ex_load,
  input  logic        ex_md_start,
  input  logic        ex_mispredict,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        feedforward_stall,
  output logic        checkpre_flush,
  output logic        exmem_bubble,
  output logic        exmem_stall,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] perf_stall_cnt
);

  // The start cycle in IDLE is the first stall cycle, so BUSY needs
  // MD_LATENCY-2 further stall cycles before the done cycle.
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY - 2);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       perf_q, perf_d;

  logic              rs1_hit;
  logic              rs2_hit;
  logic              lu_hit;

  // Load-use detection: a load in EX feeding a source read by the valid
  // instruction in ID. A load to x0 never creates a dependence.
  always_comb begin
    rs1_hit = id_rs1_en && (id_rs1 == ex_rd);
    rs2_hit = id_rs2_en && (id_rs2 == ex_rd);
    lu_hit  = ex_load && ex_rd_en && (ex_rd != 5'd0) && id_valid &&
              (rs1_hit || rs2_hit);
  end

  // Prioritised hazard resolution and sequencer next state. A memory freeze
  // outranks everything, because EX is held and whatever sits there will be
  // re-evaluated once memory is ready. The ID/EX hold and the ID/EX bubble
  // are driven from disjoint branches, so they can never both be active.
  always_comb begin
    pc_stall          = 1'b0;
    ifid_stall        = 1'b0;
    ifid_flush        = 1'b0;
    feedforward_stall = 1'b0;
    checkpre_flush    = 1'b0;
    exmem_bubble      = 1'b0;
    exmem_stall       = 1'b0;
    md_busy           = 1'b0;
    md_done           = 1'b0;
    state_d           = state_q;
    cnt_d             = cnt_q;

    if (rst) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      md_busy = (state_q == BUSY);
      if (mem_busy) begin
        pc_stall          = 1'b1;
        ifid_stall        = 1'b1;
        feedforward_stall = 1'b1;
        exmem_stall       = 1'b1;
      end else if (state_q == BUSY) begin
        if (cnt_q != '0) begin
          pc_stall          = 1'b1;
          ifid_stall        = 1'b1;
          feedforward_stall = 1'b1;
          exmem_bubble      = 1'b1;
          cnt_d             = cnt_q - 1'b1;
        end else begin
          md_done = 1'b1;
          state_d = IDLE;
        end
      end else if (ex_mispredict) begin
        ifid_flush     = 1'b1;
        checkpre_flush = 1'b1;
      end else if (ex_md_start) begin
        pc_stall          = 1'b1;
        ifid_stall        = 1'b1;
        feedforward_stall = 1'b1;
        exmem_bubble      = 1'b1;
        state_d           = BUSY;
        cnt_d             = MD_LOAD;
      end else if (lu_hit) begin
        pc_stall       = 1'b1;
        ifid_stall     = 1'b1;
        checkpre_flush = 1'b1;
      end
    end
  end

  // Stall-cycle counter; wraps naturally at 2^32.
  always_comb begin
    perf_d = perf_q;
    if (pc_stall) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // State, occupancy counter and performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MD_LATENCY = 33).
// Inputs change on the falling edge; outputs are sampled 1 ns later.

module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_rs1_en, id_rs2_en;
  logic [4:0]  ex_rd;
  logic        ex_rd_en, ex_load, ex_md_start, ex_mispredict, mem_busy;
  logic        pc_stall, ifid_stall, ifid_flush, feedforward_stall;
  logic        checkpre_flush, exmem_bubble, exmem_stall, md_busy, md_done;
  logic [31:0] perf_stall_cnt;

  int checks = 0;
  int passes = 0;

  // Output bundle, MSB first: pc_stall .. md_done
  localparam logic [8:0] B_PC  = 9'b1_0000_0000;
  localparam logic [8:0] B_IFS = 9'b0_1000_0000;
  localparam logic [8:0] B_IFF = 9'b0_0100_0000;
  localparam logic [8:0] B_FFS = 9'b0_0010_0000;
  localparam logic [8:0] B_CPF = 9'b0_0001_0000;
  localparam logic [8:0] B_EXB = 9'b0_0000_1000;
  localparam logic [8:0] B_EXS = 9'b0_0000_0100;
  localparam logic [8:0] B_MDB = 9'b0_0000_0010;
  localparam logic [8:0] B_MDD = 9'b0_0000_0001;

  localparam logic [8:0] LU_STALL = B_PC | B_IFS | B_CPF;
  localparam logic [8:0] MD_STALL = B_PC | B_IFS | B_FFS | B_EXB;
  localparam logic [8:0] FREEZE   = B_PC | B_IFS | B_FFS | B_EXS;
  localparam logic [8:0] FLUSH    = B_IFF | B_CPF;

  wire [8:0] ctl = {pc_stall, ifid_stall, ifid_flush, feedforward_stall,
                    checkpre_flush, exmem_bubble, exmem_stall, md_busy, md_done};

  pipeline_hazard_ctrl #(.MD_LATENCY(33), .CNT_W(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid          (id_valid),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_rs1_en         (id_rs1_en),
    .id_rs2_en         (id_rs2_en),
    .ex_rd             (ex_rd),
    .ex_rd_en          (ex_rd_en),
    .ex_load           (ex_load),
    .ex_md_start       (ex_md_start),
    .ex_mispredict     (ex_mispredict),
    .mem_busy          (mem_busy),
    .pc_stall          (pc_stall),
    .ifid_stall        (ifid_stall),
    .ifid_flush        (ifid_flush),
    .feedforward_stall (feedforward_stall),
    .checkpre_flush    (checkpre_flush),
    .exmem_bubble      (exmem_bubble),
    .exmem_stall       (exmem_stall),
    .md_busy           (md_busy),
    .md_done           (md_done),
    .perf_stall_cnt    (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_rs1_en = 1'b0; id_rs2_en = 1'b0;
    ex_rd = 5'd0; ex_rd_en = 1'b0; ex_load = 1'b0;
    ex_md_start = 1'b0; ex_mispredict = 1'b0; mem_busy = 1'b0;
  endtask

  // Leaves the bench just after a falling edge with rst low.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_load = 1'b1; ex_rd_en = 1'b1; ex_rd = rd;
    id_valid = 1'b1; id_rs2 = rd; id_rs2_en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    ex_md_start = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ctl !== (MD_STALL | B_MDB))
      $display("[TB] FAIL reset_pre_busy ctl got %b want %b", ctl, MD_STALL | B_MDB);
    else passes++;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== 9'b0) $display("[TB] FAIL reset_ctl[%0d] got %b want %b", i, ctl, 9'b0);
      else passes++;
      @(negedge clk);
      checks++;
      if (perf_stall_cnt !== 32'd0)
        $display("[TB] FAIL reset_perf[%0d] got %0d want 0", i, perf_stall_cnt);
      else passes++;
    end
    rst = 1'b0;
    ex_md_start = 1'b0;
    #1;
    checks++;
    if (ctl !== 9'b0) $display("[TB] FAIL reset_idle got %b want %b", ctl, 9'b0);
    else passes++;
    // A start seen now must be treated as an IDLE start (md_busy low).
    ex_md_start = 1'b1;
    #1;
    checks++;
    if (ctl !== MD_STALL) $display("[TB] FAIL reset_restart got %b want %b", ctl, MD_STALL);
    else passes++;
    @(negedge clk);
    ex_md_start = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd5);
    #1;
    checks++;
    if (ctl !== LU_STALL) $display("[TB] FAIL lu_stall got %b want %b", ctl, LU_STALL);
    else passes++;
    @(negedge clk);
    ex_load = 1'b0; ex_rd_en = 1'b0;
    #1;
    checks++;
    if (ctl !== 9'b0) $display("[TB] FAIL lu_one_bubble got %b want %b", ctl, 9'b0);
    else passes++;
    checks++;
    if (perf_stall_cnt !== 32'd1) $display("[TB] FAIL lu_perf got %0d want 1", perf_stall_cnt);
    else passes++;
    set_load_use(5'd0);
    #1;
    checks++;
    if (ctl !== 9'b0) $display("[TB] FAIL lu_x0 got %b want %b", ctl, 9'b0);
    else passes++;
    clear_inputs();
    ex_load = 1'b1; ex_rd_en = 1'b1; ex_rd = 5'd9;
    id_valid = 1'b1; id_rs1 = 5'd9; id_rs1_en = 1'b0;
    #1;
    checks++;
    if (ctl !== 9'b0) $display("[TB] FAIL lu_rs1_disabled got %b want %b", ctl, 9'b0);
    else passes++;
    id_rs1_en = 1'b1;
    #1;
    checks++;
    if (ctl !== LU_STALL) $display("[TB] FAIL lu_rs1 got %b want %b", ctl, LU_STALL);
    else passes++;
    id_valid = 1'b0;
    #1;
    checks++;
    if (ctl !== 9'b0) $display("[TB] FAIL lu_id_invalid got %b want %b", ctl, 9'b0);
    else passes++;
    ex_load = 1'b0; id_valid = 1'b1;
    #1;
    checks++;
    if (ctl !== 9'b0) $display("[TB] FAIL lu_not_load got %b want %b", ctl, 9'b0);
    else passes++;
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_muldiv();
    logic [8:0] exp;
    do_reset();
    ex_md_start = 1'b1;
    for (int c = 0; c <= 32; c++) begin
      if (c == 32) ex_md_start = 1'b0;
      #1;
      if (c < 32) exp = MD_STALL | ((c >= 1) ? B_MDB : 9'b0);
      else exp = B_MDB | B_MDD;
      checks++;
      if (ctl !== exp) $display("[TB] FAIL md_cycle%0d got %b want %b", c, ctl, exp);
      else passes++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (ctl !== 9'b0) $display("[TB] FAIL md_after got %b want %b", ctl, 9'b0);
    else passes++;
    checks++;
    if (perf_stall_cnt !== 32'd32) $display("[TB] FAIL md_perf got %0d want 32", perf_stall_cnt);
    else passes++;
  endtask

  task automatic test_mem_busy_in_busy();
    logic [8:0] exp;
    do_reset();
    ex_md_start = 1'b1;
    for (int c = 0; c <= 36; c++) begin
      mem_busy = (c >= 10 && c <= 13);
      if (c == 36) ex_md_start = 1'b0;
      #1;
      if (c == 36) exp = B_MDB | B_MDD;
      else if (mem_busy) exp = FREEZE | B_MDB;
      else exp = MD_STALL | ((c >= 1) ? B_MDB : 9'b0);
      checks++;
      if (ctl !== exp) $display("[TB] FAIL mb_cycle%0d got %b want %b", c, ctl, exp);
      else passes++;
      @(negedge clk);
    end
    mem_busy = 1'b0;
    #1;
    checks++;
    if (perf_stall_cnt !== 32'd36) $display("[TB] FAIL mb_perf got %0d want 36", perf_stall_cnt);
    else passes++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_load_use(5'd3);
    ex_mispredict = 1'b1;
    #1;
    checks++;
    if (ctl !== FLUSH) $display("[TB] FAIL sim_flush got %b want %b", ctl, FLUSH);
    else passes++;
    @(negedge clk);
    mem_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== FREEZE) $display("[TB] FAIL sim_freeze[%0d] got %b want %b", i, ctl, FREEZE);
      else passes++;
      @(negedge clk);
    end
    mem_busy = 1'b0;
    #1;
    checks++;
    if (ctl !== FLUSH) $display("[TB] FAIL sim_flush_after got %b want %b", ctl, FLUSH);
    else passes++;
    clear_inputs();
    ex_mispredict = 1'b1; ex_md_start = 1'b1;
    #1;
    checks++;
    if (ctl !== FLUSH) $display("[TB] FAIL sim_md_flush got %b want %b", ctl, FLUSH);
    else passes++;
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (ctl !== 9'b0) $display("[TB] FAIL sim_md_ignored got %b want %b", ctl, 9'b0);
    else passes++;
    checks++;
    if (perf_stall_cnt !== 32'd2) $display("[TB] FAIL sim_perf got %0d want 2", perf_stall_cnt);
    else passes++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_load_use(5'd5);
    #1;
    checks++;
    if (ctl !== LU_STALL) $display("[TB] FAIL b2b_first got %b want %b", ctl, LU_STALL);
    else passes++;
    @(negedge clk);
    clear_inputs();
    ex_load = 1'b1; ex_rd_en = 1'b1; ex_rd = 5'd7;
    id_valid = 1'b1; id_rs1 = 5'd7; id_rs1_en = 1'b1;
    #1;
    checks++;
    if (ctl !== LU_STALL) $display("[TB] FAIL b2b_second got %b want %b", ctl, LU_STALL);
    else passes++;
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (perf_stall_cnt !== 32'd2) $display("[TB] FAIL b2b_perf got %0d want 2", perf_stall_cnt);
    else passes++;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    force dut.perf_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_q;
    set_load_use(5'd12);
    #1;
    checks++;
    if (perf_stall_cnt !== 32'hFFFF_FFFF)
      $display("[TB] FAIL wrap_preload got %h want ffffffff", perf_stall_cnt);
    else passes++;
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (perf_stall_cnt !== 32'd0) $display("[TB] FAIL wrap_zero got %h want 00000000", perf_stall_cnt);
    else passes++;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_muldiv();
    test_mem_busy_in_busy();
    test_simultaneous();
    test_back_to_back();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard controller for the 5-stage RV32 pipeline. It drives `feedforward_stall` and `checkpre_flush` into the ID/EX register, plus matching stall and flush controls for the PC and IF/ID. It also owns the multi-cycle MUL/DIV occupancy sequencer and a stall-cycle performance counter. It consumes decode-stage operand indices and EX-stage status taken from the ID/EX outputs.

## Interface
- `MD_LATENCY`, default 33: cycles a MUL/DIV instruction occupies EX. Legal range 2..63.
- `CNT_W`, default 6: width of the occupancy counter. Must satisfy 2^CNT_W > MD_LATENCY.

Ports:
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `id_valid`  in  1: the IF/ID slot holds a real instruction.
- `id_rs1`, `id_rs2`  in  5 each: source register indices of the instruction in ID.
- `id_rs1_en`, `id_rs2_en`  in  1 each: each source is actually read.
- `ex_rd`  in  5: destination register of the instruction in EX.
- `ex_rd_en`  in  1: the instruction in EX writes `ex_rd`.
- `ex_load`  in  1: the instruction in EX is a load.
- `ex_md_start`  in  1: the instruction in EX is a multi-cycle MUL/DIV.
- `ex_mispredict`  in  1: the branch or jump in EX resolved against the prediction.
- `mem_busy`  in  1: data memory not ready; the whole pipeline must freeze.
- `pc_stall`  out  1: hold the PC.
- `ifid_stall`  out  1: hold IF/ID.
- `ifid_flush`  out  1: load IF/ID with a NOP.
- `feedforward_stall`  out  1: hold ID/EX.
- `checkpre_flush`  out  1: load ID/EX with a bubble.
- `exmem_bubble`  out  1: EX/MEM captures a bubble this cycle because EX is still occupied.
- `exmem_stall`  out  1: hold EX/MEM and MEM/WB.
- `md_busy`  out  1: the sequencer is in BUSY.
- `md_done`  out  1: single-cycle pulse; the MUL/DIV result advances into EX/MEM.
- `perf_stall_cnt`  out  32: count of cycles with `pc_stall`=1. Wraps modulo 2^32.

## Operation
- **State machine.**
  - States: IDLE and BUSY. Registers: `state`, `cnt[CNT_W-1:0]`, `perf_stall_cnt`.
  - `md_busy` = (state == BUSY).
- **Hazard definition.** `lu_hit` = `ex_load` & `ex_rd_en` & (`ex_rd` != 0) & `id_valid` & ((`id_rs1_en` & `id_rs1` == `ex_rd`) | (`id_rs2_en` & `id_rs2` == `ex_rd`)).
- **Priority (combinational outputs), highest first:**
  1. `rst`: all outputs 0.
  2. `mem_busy`: `pc_stall`, `ifid_stall`, `feedforward_stall` and `exmem_stall` are 1; every other control is 0. Mispredict and load-use are suppressed and re-evaluate once `mem_busy` drops, because EX is held. `cnt` is frozen, `md_done` is 0, and there is no state change.
  3. BUSY with `cnt` != 0: `pc_stall`, `ifid_stall`, `feedforward_stall` and `exmem_bubble` are 1. Then `cnt` <= `cnt`-1.
  4. BUSY with `cnt` == 0: `md_done` is 1 and all stalls are 0. Then `state` <= IDLE. `ex_md_start` is ignored throughout BUSY.
  5. IDLE with `ex_mispredict`: `ifid_flush` and `checkpre_flush` are 1 and there are no stalls. A simultaneous `lu_hit` is ignored.
  6. IDLE with `ex_md_start`: same stall set as item 3. Then `state` <= BUSY and `cnt` <= MD_LATENCY-2. If `ex_mispredict` is also high, `ex_mispredict` takes precedence (item 5) and `ex_md_start` is ignored.
  7. IDLE with `lu_hit`: `pc_stall`, `ifid_stall` and `checkpre_flush` are 1 for exactly one cycle. The bubble separates the load from its consumer; the next cycle re-evaluates with the load in MEM.
  8. Otherwise: all outputs 0.
- **Invariant.** `feedforward_stall` and `checkpre_flush` are never both 1.
- **Performance counter.** `perf_stall_cnt` increments on every edge where `pc_stall`=1 and `rst`=0.

## Timing
- **Reset.** On a `rst` edge: `state` = IDLE, `cnt` = 0, `perf_stall_cnt` = 0. All outputs read 0 while `rst` is high. Reset mid-BUSY returns to IDLE on the next edge.
- **Latency.** Hazard outputs are combinational from the current inputs and state. They have zero-cycle latency to the pipeline registers' next edge.
- **MUL/DIV sequence.** With `ex_md_start` first seen in IDLE at cycle 0:
  - Stalls are asserted in cycles 0..MD_LATENCY-2 (MD_LATENCY-1 cycles total).
  - `md_done` pulses in cycle MD_LATENCY-1; the next instruction enters EX at that edge.
  - Each `mem_busy` cycle inside the window extends it by one cycle.
- **Load-use.** Exactly one bubble per load-use pair. Dependence on `x0` never stalls.
- **Mispredict.** The flush is asserted in the same cycle as `ex_mispredict`, and only when `mem_busy`=0.

## Test plan
- Reset: hold `rst`=1 for 3 cycles during BUSY -> all outputs 0, `perf_stall_cnt`=0, and IDLE after release.
- Load-use: `ex_load`=1, `ex_rd`=5, `id_rs2`=5, `id_rs2_en`=1 -> one cycle with `pc_stall`=`ifid_stall`=`checkpre_flush`=1 and `feedforward_stall`=0. The same case with `ex_rd`=0 -> no stall.
- MUL/DIV: MD_LATENCY=33, `ex_md_start` held high -> stalls for 32 cycles, `md_done` high in cycle 32, `perf_stall_cnt`=32.
- `mem_busy` inside BUSY: assert it for 4 cycles at cycle 10 -> `md_done` moves to cycle 36 and `exmem_stall`=1 only during those 4 cycles.
- Simultaneous events: `ex_mispredict`=1 together with `lu_hit`=1 -> `ifid_flush`=`checkpre_flush`=1 and no stall. The same with `mem_busy`=1 -> freeze only, and the flush fires in the first cycle after `mem_busy` drops.
- Counter wrap: preload `perf_stall_cnt`=0xFFFFFFFF through a bench force, then one stall cycle -> `perf_stall_cnt`=0.
